// File: rtl/apb3_requester.sv
// apb3_requester
//   Converts a valid/ready command stream into single APB3 read/write
//   transfers, one in flight at a time, and returns each result on a
//   valid/ready response stream. Transfers whose completer never asserts
//   pready are aborted after TIMEOUT_CYCLES ACCESS cycles (0 = never).
//
// Ports
//   clk, rst                       clock; asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write, cmd_addr, cmd_wdata command fields
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata, rsp_err, rsp_timeout response fields
//   psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr
//                                  APB3 requester-side bus
module apb3_requester #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int unsigned CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = SETUP;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_write ? cmd_wdata : '0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        // pready is tested first so a completion on the last allowed
        // cycle beats the timeout.
        if (pready) begin
          state_d       = RESP;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          state_d       = RESP;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus and response strobes are registered copies of the next state.
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = rst && (state_q == IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb3_requester.sv
module tb_apb3_requester;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int vectors = 0;
  int miscompares = 0;

  apb3_requester #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer. w = number of pready=0 cycles the completer
  // inserts before pready=1; hold = extra cycles of response back-pressure.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int w, input logic err, input int hold);
    int          n;
    logic        exp_to;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] exp_pw;
    // Reference model: transfer completes on ACCESS cycle w+1 unless that
    // lies beyond the timeout window, in which case it aborts on cycle T.
    exp_to  = (w >= T);
    n       = exp_to ? T : w + 1;
    exp_err = exp_to ? 1'b1 : err;
    exp_rd  = (exp_to || wr) ? 32'h0 : rdata;
    exp_pw  = wr ? wdata : 32'h0;

    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_psel", psel, 0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;

    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~wr;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, addr);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_pwdata", pwdata, exp_pw);
    chk("setup_cmd_ready", cmd_ready, 0);
    chk("setup_rsp_valid", rsp_valid, 0);

    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_paddr", paddr, addr);
      chk("access_pwrite", pwrite, wr);
      chk("access_pwdata", pwdata, exp_pw);
      chk("access_rsp_valid", rsp_valid, 0);
      if (k == w + 1) begin
        pready = 1'b1; prdata = rdata; pslverr = err;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      end
    end

    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      chk("resp_psel", psel, 0);
      chk("resp_penable", penable, 0);
      chk("resp_valid", rsp_valid, 1);
      chk("resp_rdata", rsp_rdata, exp_rd);
      chk("resp_err", rsp_err, exp_err);
      chk("resp_timeout", rsp_timeout, exp_to);
      chk("resp_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;

    @(negedge clk);
    rsp_ready = 1'b0;
    chk("after_rsp_valid", rsp_valid, 0);
    chk("after_cmd_ready", cmd_ready, 1);
    chk("after_psel", psel, 0);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    rst = 1'b1;

    // Write, zero wait
    xfer(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 1'b0, 0);
    // Read with three wait states
    xfer(1'b0, 32'h0000_0100, 32'hAAAA_5555, 32'h1234_5678, 3, 1'b0, 0);
    // Slave error on a read
    xfer(1'b0, 32'h0000_0204, 32'h0, 32'hCAFE_F00D, 1, 1'b1, 0);
    // Timeout: pready never arrives
    xfer(1'b0, 32'h0000_0300, 32'h0, 32'h5A5A_5A5A, 100, 1'b0, 0);
    xfer(1'b1, 32'h0000_0304, 32'h1111_2222, 32'h5A5A_5A5A, T, 1'b0, 1);
    // Timeout boundary: pready on ACCESS cycle T wins
    xfer(1'b0, 32'h0000_0400, 32'h0, 32'h8765_4321, T - 1, 1'b0, 0);
    // Response back-pressure for 10 cycles
    xfer(1'b1, 32'h0000_0500, 32'h0BAD_CAFE, 32'h0, 2, 1'b1, 10);

    // Reset asserted during ACCESS
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h600; cmd_wdata = 32'h7777;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_penable", penable, 1);
    rst = 1'b0;
    #1;
    chk("async_psel", psel, 0);
    chk("async_penable", penable, 0);
    chk("async_paddr", paddr, 0);
    chk("async_cmd_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_cmd_ready", cmd_ready, 1);
    rsp_ready = 1'b1; pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_psel", psel, 0);
      chk("post_rst_cmd_ready", cmd_ready, 1);
    end
    rsp_ready = 1'b0; pready = 1'b0;

    // Randomized transfers
    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 6)),
           1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
